// File: rtl/spiflash_target.sv
// spiflash_target: SPI NOR flash responder backed by a synchronous byte memory.
// Decodes command/address/dummy phases sampled on flash_clk rises and returns
// read data in single (0x03/0x0B), dual (0x3B) or quad (0x6B) mode.
// All flash_* inputs share the clk domain, so edges are found by comparing
// against the previous clk sample; no synchronizers.
// Ports:
//   clk, resetn            system clock, async active-low reset
//   flash_csb, flash_clk   chip select (low active), SPI mode-0 clock
//   flash_ioN_di/do/oe     pad in / out / output enable, N = 0..3
//   mem_rd, mem_addr       one-cycle read strobe and address (combinational)
//   mem_rdata              read data, valid exactly one clk after mem_rd
//   busy, last_cmd         command in progress, last decoded opcode
module spiflash_target #(
  parameter int ADDR_BITS  = 24,
  parameter int DUMMY_CLKS = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flash_csb,
  input  logic                 flash_clk,
  input  logic                 flash_io0_di,
  input  logic                 flash_io1_di,
  input  logic                 flash_io2_di,
  input  logic                 flash_io3_di,
  output logic                 flash_io0_do,
  output logic                 flash_io1_do,
  output logic                 flash_io2_do,
  output logic                 flash_io3_do,
  output logic                 flash_io0_oe,
  output logic                 flash_io1_oe,
  output logic                 flash_io2_oe,
  output logic                 flash_io3_oe,
  output logic                 mem_rd,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic [7:0]           last_cmd
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_e;
  localparam logic [1:0] M_SINGLE = 2'd0, M_DUAL = 2'd1, M_QUAD = 2'd2;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [6:0]           cmd_q, cmd_d;         // previous 7 opcode bits
  logic [ADDR_BITS-2:0] addr_q, addr_d;       // previous ADDR_BITS-1 address bits
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d; // address of the most recent read
  logic [7:0]           last_cmd_q, last_cmd_d;
  logic                 busy_q, busy_d;
  logic [1:0]           mode_q, mode_d;
  logic                 dum_q, dum_d;
  logic [7:0]           sr_q, sr_d, nbuf_q, nbuf_d;
  logic [3:0]           bcnt_q, bcnt_d;       // bits already shifted out of sr
  logic                 rd_pend_q, rd_pend_d, first_q, first_d, slot_q, slot_d;
  logic                 clk_q, clk_d, csb_q, csb_d;
  logic                 rise, csb_fall;
  logic [3:0]           step, nb;
  logic [7:0]           cmd_byte;
  logic                 unused_io;

  assign unused_io = ^{flash_io1_di, flash_io2_di, flash_io3_di};
  assign busy      = busy_q;
  assign last_cmd  = last_cmd_q;

  always_comb begin
    rise     = flash_clk & ~clk_q & ~flash_csb;
    csb_fall = csb_q & ~flash_csb;
    cmd_byte = {cmd_q, flash_io0_di};
    case (mode_q)
      M_SINGLE: step = 4'd1;
      M_DUAL:   step = 4'd2;
      default:  step = 4'd4;
    endcase
    nb = bcnt_q + step;

    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    rd_addr_d  = rd_addr_q;
    last_cmd_d = last_cmd_q;
    busy_d     = busy_q;
    mode_d     = mode_q;
    dum_d      = dum_q;
    sr_d       = sr_q;
    bcnt_d     = bcnt_q;
    nbuf_d     = rd_pend_q ? mem_rdata : nbuf_q;
    rd_pend_d  = 1'b0;
    first_d    = first_q;
    // only rises seen while already in DATA consume a bit group
    slot_d     = rise && (state_q == DATA);
    clk_d      = flash_clk;
    csb_d      = flash_csb;
    mem_rd     = 1'b0;
    mem_addr   = rd_addr_q;

    case (state_q)
      IDLE: if (csb_fall) begin
        state_d = CMD;
        cnt_d   = '0;
      end
      CMD: if (rise) begin
        cmd_d = cmd_byte[6:0];
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd7) begin
          last_cmd_d = cmd_byte;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = ADDR;
          case (cmd_byte)
            8'h03:   begin mode_d = M_SINGLE; dum_d = 1'b0; end
            8'h0B:   begin mode_d = M_SINGLE; dum_d = (DUMMY_CLKS > 0); end
            8'h3B:   begin mode_d = M_DUAL;   dum_d = (DUMMY_CLKS > 0); end
            8'h6B:   begin mode_d = M_QUAD;   dum_d = (DUMMY_CLKS > 0); end
            default: state_d = IGNORE;
          endcase
        end
      end
      ADDR: if (rise) begin
        addr_d = {addr_q[ADDR_BITS-3:0], flash_io0_di};
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == 8'(ADDR_BITS-1)) begin
          mem_rd    = 1'b1;
          mem_addr  = {addr_q, flash_io0_di};
          rd_addr_d = {addr_q, flash_io0_di};
          rd_pend_d = 1'b1;
          cnt_d     = '0;
          if (dum_q) state_d = DUMMY;
          else begin
            state_d = DATA;
            first_d = 1'b1;
          end
        end
      end
      DUMMY: if (rise) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(DUMMY_CLKS-1)) begin
          state_d = DATA;
          first_d = 1'b1;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (first_q) begin
          // no dummy: data is arriving this cycle; with dummy it was parked in nbuf
          sr_d    = rd_pend_q ? mem_rdata : nbuf_q;
          bcnt_d  = '0;
          first_d = 1'b0;
        end else if (slot_q) begin
          if (nb == 4'd8) begin
            sr_d   = nbuf_q;
            bcnt_d = '0;
          end else begin
            sr_d   = sr_q << step;
            bcnt_d = nb;
          end
          // prefetch one slot ahead so nbuf is full before the byte runs out
          if (nb == 4'd8 - step) begin
            mem_rd    = 1'b1;
            mem_addr  = rd_addr_q + 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            rd_pend_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (flash_csb) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      cnt_d     = '0;
      bcnt_d    = '0;
      first_d   = 1'b0;
      rd_pend_d = 1'b0;
      slot_d    = 1'b0;
      mem_rd    = 1'b0;
    end
  end

  always_comb begin
    {flash_io3_oe, flash_io2_oe, flash_io1_oe, flash_io0_oe} = 4'b0000;
    {flash_io3_do, flash_io2_do, flash_io1_do, flash_io0_do} = 4'b0000;
    if (state_q == DATA && !first_q) begin
      case (mode_q)
        M_SINGLE: begin
          flash_io1_oe = 1'b1;
          flash_io1_do = sr_q[7];
        end
        M_DUAL: begin
          {flash_io1_oe, flash_io0_oe} = 2'b11;
          {flash_io1_do, flash_io0_do} = sr_q[7:6];
        end
        M_QUAD: begin
          {flash_io3_oe, flash_io2_oe, flash_io1_oe, flash_io0_oe} = 4'b1111;
          {flash_io3_do, flash_io2_do, flash_io1_do, flash_io0_do} = sr_q[7:4];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      rd_addr_q  <= '0;
      last_cmd_q <= '0;
      busy_q     <= 1'b0;
      mode_q     <= M_SINGLE;
      dum_q      <= 1'b0;
      sr_q       <= '0;
      nbuf_q     <= '0;
      bcnt_q     <= '0;
      rd_pend_q  <= 1'b0;
      first_q    <= 1'b0;
      slot_q     <= 1'b0;
      clk_q      <= 1'b0;
      // a low reset value means csb already low at reset release is not a start
      csb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      rd_addr_q  <= rd_addr_d;
      last_cmd_q <= last_cmd_d;
      busy_q     <= busy_d;
      mode_q     <= mode_d;
      dum_q      <= dum_d;
      sr_q       <= sr_d;
      nbuf_q     <= nbuf_d;
      bcnt_q     <= bcnt_d;
      rd_pend_q  <= rd_pend_d;
      first_q    <= first_d;
      slot_q     <= slot_d;
      clk_q      <= clk_d;
      csb_q      <= csb_d;
    end
  end

endmodule
